// File: rtl/uart_tx_pkg.sv
// Purpose : shared types and constants for the FIFO-fed UART transmitter.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: uart_tx_state_t (frame FSM states), UART_DATA_BITS, UART_IDLE_LEVEL,
//           even_parity() helper used when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Purpose : free-running bit-period counter; tick marks the last cycle of a bit.
// Latency : tick is combinational from the count; one tick every CLKS_PER_BIT cycles.
// Backpr. : none; clear restarts the period so the next tick is CLKS_PER_BIT cycles away.
// Ports   : clk, reset (async, active-high), clear (sync restart), tick (1-cycle pulse).
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // Guard keeps the width legal even if an illegal value slips through;
  // the top level rejects CLKS_PER_BIT < 2 at elaboration.
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Purpose : drains an 8-bit sync FIFO and serialises each byte as a UART frame.
// Latency : start bit begins 3 cycles after IDLE sees a non-empty FIFO; frames F+3 apart.
// Backpr. : reads only when the FIFO is non-empty and enable is high, sampled in IDLE.
// Ports   : clk, reset (async, active-high), enable, fifo_empty, fifo_data[7:0] in;
//           fifo_rd_en (registered 1-cycle pulse), tx (pad, idle high), busy out.
// Config  : define UART_TX_PARITY_EN to append an even-parity bit after data bit 7.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $fatal(1, "fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

  uart_tx_state_t            state, state_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic [2:0]                bit_cnt, bit_cnt_nxt;
  logic                      tx_nxt;
  logic                      tick;
  logic                      baud_clear;

`ifdef UART_TX_PARITY_EN
  logic par, par_nxt;
`endif

  // Restarting the baud counter in LOAD aligns the start bit to a full period.
  assign baud_clear = (state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      // Outputs are decoded from the next state so they line up with the
      // state they describe while still coming straight from flops.
      fifo_rd_en <= (state_nxt == FETCH);
      busy       <= (state_nxt != IDLE);
      tx         <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      par        <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par;
`endif

    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_nxt = FETCH;
        end
      end

      FETCH: begin
        state_nxt = LOAD;
      end

      LOAD: begin
        // fifo_data is valid here, one cycle after the read pulse.
        shreg_nxt   = fifo_data;
        bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
        par_nxt     = even_parity(fifo_data);
`endif
        state_nxt   = START;
      end

      START: begin
        if (tick) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          shreg_nxt   = {1'b0, shreg[UART_DATA_BITS-1:1]};
          // Wraps 7 -> 0 on the last bit, leaving the counter ready for STOP.
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Line level for the state being entered.
  always_comb begin
    tx_nxt = UART_IDLE_LEVEL;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par;
`endif
      default: tx_nxt = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose : self-checking bench for fifo_uart_tx with a behavioural FIFO and frame model.
// Latency : n/a.
// Backpr. : n/a.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F      = (1 + 8 + P + SB) * CPB;  // frame length in cycles
  localparam int PERIOD = F + 3;                   // read-pulse spacing

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural FIFO: wr_ptr owned by the stimulus, rd_ptr by the read process.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         underflows = 0;

  logic tx_log   [0:511];
  logic busy_log [0:511];
  logic rd_log   [0:511];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= 8'h00;
    end else if (fifo_rd_en) begin
      if (fifo_empty) begin
        underflows <= underflows + 1;
      end else begin
        fifo_data <= mem[rd_ptr % 256];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Records n negedge samples into the logs starting at index off.
  task automatic capture(input int off, input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[off + i]   = tx;
      busy_log[off + i] = busy;
      rd_log[off + i]   = fifo_rd_en;
      @(negedge clk);
    end
  endtask

  // Waits for a read pulse; waited = negedges advanced, -1 on timeout.
  task automatic wait_rd(input int limit, output int waited);
    waited = -1;
    for (int i = 0; i <= limit; i++) begin
      if (fifo_rd_en === 1'b1) begin
        waited = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Expected line level k cycles after the read-pulse (FETCH) cycle.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bi;
    if (k < 2) return 1'b1;
    bi = (k - 2) / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi - 1];
    if (P == 1 && bi == 9) return ^b;
    return 1'b1;
  endfunction

  // Mid-bit sampling of the logged line, frame starting at FETCH index base.
  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = tx_log[base + 2 + CPB * (1 + j) + CPB / 2];
    return d;
  endfunction

  task automatic test_reset;
    int bad_tx, bad_busy, bad_rd;
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", fifo_rd_en); end
    reset  = 1'b0;
    enable = 1'b1;
    capture(0, 20);
    bad_tx = 0; bad_busy = 0; bad_rd = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_log[i] !== 1'b1) bad_tx++;
      if (busy_log[i] !== 1'b0) bad_busy++;
      if (rd_log[i] !== 1'b0) bad_rd++;
    end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL empty_tx bad_cycles=%0d exp=0", bad_tx); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL empty_busy bad_cycles=%0d exp=0", bad_busy); end
    checks++; if (bad_rd != 0) begin failures++; $display("FAIL empty_rd pulses=%0d exp=0", bad_rd); end
  endtask

  task automatic test_single_byte;
    int w, bad, nbusy, nrd;
    enable = 1'b1;
    push(8'hA5);
    wait_rd(10, w);
    checks++; if (w != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", w); end
    if (w < 0) return;
    capture(0, PERIOD + 1);
    bad = 0; nbusy = 0; nrd = 0;
    for (int k = 0; k <= F + 2; k++) if (tx_log[k] !== exp_tx(8'hA5, k)) bad++;
    for (int k = 0; k <= F + 3; k++) begin
      if (busy_log[k] === 1'b1) nbusy++;
      if (rd_log[k] === 1'b1) nrd++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_tx_seq bad_cycles=%0d exp=0", bad); end
    checks++; if (nbusy != F + 2 || busy_log[F + 1] !== 1'b1) begin
      failures++; $display("FAIL single_busy got=%0d cycles exp=%0d", nbusy, F + 2); end
    checks++; if (nrd != 1) begin failures++; $display("FAIL single_rd pulses=%0d exp=1", nrd); end
    checks++; if (decode(0) !== 8'hA5) begin failures++; $display("FAIL single_decode got=%h exp=a5", decode(0)); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    int w, nrd, bad_pos, nlow;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    @(negedge clk);
    enable = 1'b1;
    wait_rd(10, w);
    checks++; if (w != 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", w); end
    if (w < 0) return;
    capture(0, 3 * PERIOD);
    nrd = 0; bad_pos = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      if (rd_log[i] === 1'b1) begin
        nrd++;
        if (i % PERIOD != 0) bad_pos++;
      end
    end
    checks++; if (nrd != 3 || bad_pos != 0) begin
      failures++; $display("FAIL b2b_rd pulses=%0d misplaced=%0d exp=3/0", nrd, bad_pos); end
    for (int f = 0; f < 3; f++) begin
      checks++; if (decode(f * PERIOD) !== exp_b[f]) begin
        failures++; $display("FAIL b2b_decode frame=%0d got=%h exp=%h", f, decode(f * PERIOD), exp_b[f]); end
    end
    for (int f = 0; f < 2; f++) begin
      nlow = 0;
      for (int i = f * PERIOD; i < (f + 1) * PERIOD; i++) if (busy_log[i] !== 1'b1) nlow++;
      checks++; if (nlow != 1) begin failures++; $display("FAIL b2b_busy_gap frame=%0d got=%0d exp=1", f, nlow); end
    end
  endtask

  task automatic test_parity;
    logic [7:0] bytes [2];
    logic       par_exp [2];
    int w, nbusy;
    bytes[0] = 8'h07; par_exp[0] = 1'b1;
    bytes[1] = 8'h03; par_exp[1] = 1'b0;
    enable = 1'b1;
    for (int t = 0; t < 2; t++) begin
      logic expv;
      // Without parity the same sample point falls in the stop bit.
      expv = (P == 1) ? par_exp[t] : 1'b1;
      push(bytes[t]);
      wait_rd(10, w);
      checks++; if (w < 0) begin failures++; $display("FAIL parity_start timeout byte=%h", bytes[t]); return; end
      capture(0, PERIOD);
      checks++; if (tx_log[2 + CPB * 9 + CPB / 2] !== expv) begin
        failures++; $display("FAIL parity_bit byte=%h got=%b exp=%b", bytes[t], tx_log[2 + CPB * 9 + CPB / 2], expv); end
      nbusy = 0;
      for (int k = 0; k < PERIOD; k++) if (busy_log[k] === 1'b1) nbusy++;
      checks++; if (nbusy != ((P == 1) ? 46 : 42)) begin
        failures++; $display("FAIL parity_frame_len byte=%h got=%0d exp=%0d", bytes[t], nbusy, (P == 1) ? 46 : 42); end
    end
  endtask

  task automatic test_random_stream;
    logic [7:0] q [6];
    int w, bad;
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q[i] = 8'($urandom_range(0, 255));
      push(q[i]);
    end
    @(negedge clk);
    enable = 1'b1;
    wait_rd(10, w);
    checks++; if (w != 1) begin failures++; $display("FAIL rand_latency got=%0d exp=1", w); end
    if (w < 0) return;
    capture(0, 6 * PERIOD);
    bad = 0;
    for (int i = 0; i < 6 * PERIOD; i++) if (tx_log[i] !== exp_tx(q[i / PERIOD], i % PERIOD)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_tx_seq bad_cycles=%0d exp=0", bad); end
    for (int f = 0; f < 6; f++) begin
      checks++; if (decode(f * PERIOD) !== q[f]) begin
        failures++; $display("FAIL rand_decode frame=%0d got=%h exp=%h", f, decode(f * PERIOD), q[f]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int w, bad_tx, nrd;
    enable = 1'b1;
    push(8'hA5);
    wait_rd(10, w);
    checks++; if (w < 0) begin failures++; $display("FAIL rst_mid_start timeout"); return; end
    // Middle of data bit 3 (a zero in 0xA5).
    repeat (2 + CPB * 4 + 1) @(negedge clk);
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got tx=%b busy=%b exp tx=0 busy=1", tx, busy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx_async got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_async got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    capture(0, 20);
    bad_tx = 0; nrd = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_log[i] !== 1'b1) bad_tx++;
      if (rd_log[i] === 1'b1) nrd++;
    end
    checks++; if (nrd != 0) begin failures++; $display("FAIL rst_mid_rd pulses=%0d exp=0", nrd); end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL rst_mid_tx_idle bad_cycles=%0d exp=0", bad_tx); end
  endtask

  task automatic test_enable_hold;
    int w, nrd, bad_tx;
    enable = 1'b0;
    push(8'h11);
    push(8'h22);
    @(negedge clk);
    enable = 1'b1;
    wait_rd(10, w);
    checks++; if (w < 0) begin failures++; $display("FAIL en_start timeout"); return; end
    capture(0, 3);
    enable = 1'b0;  // inside the start bit
    capture(3, F + 50);
    checks++; if (decode(0) !== 8'h11) begin failures++; $display("FAIL en_first_decode got=%h exp=11", decode(0)); end
    nrd = 0; bad_tx = 0;
    for (int i = 1; i < F + 53; i++) if (rd_log[i] === 1'b1) nrd++;
    for (int i = F + 2; i < F + 53; i++) if (tx_log[i] !== 1'b1) bad_tx++;
    checks++; if (nrd != 0) begin failures++; $display("FAIL en_hold_rd pulses=%0d exp=0", nrd); end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL en_hold_tx bad_cycles=%0d exp=0", bad_tx); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL en_resume_rd got=%b exp=1", fifo_rd_en); end
    capture(0, PERIOD);
    checks++; if (decode(0) !== 8'h22) begin failures++; $display("FAIL en_second_decode got=%h exp=22", decode(0)); end
  endtask

  task automatic test_no_underflow;
    checks++; if (underflows != 0) begin failures++; $display("FAIL underflow count=%0d exp=0", underflows); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_random_stream();
    test_reset_mid_frame();
    test_enable_hold();
    test_no_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
